cmp_seq_ctrl: RTL
=================

CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  compare request, sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 busy  output  1  high while a compare is in progress (RUN or DONE state).
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 xgty  output  1  result: a > b.
REQ-010 xlty  output  1  result: a < b.
REQ-011 xeqy  output  1  result: a == b.
REQ-012 One clock; reset is synchronous and active-high.

Function
REQ-013 Each slice compare SHALL be made by one instantiated compr_2, 2 bits per cycle, MSB slice first.
- x input: the top 2 bits of the a shift register.
- y input: the top 2 bits of the b shift register.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE->RUN: start=1.
- RUN->DONE: last slice processed, or (early exit only) a differing slice found.
- DONE->IDLE: unconditional, after one cycle.
REQ-015 On the edge where start is accepted, the block SHALL:
- load a and b into the shift registers;
- load the slice counter with WIDTH/2;
- clear xgty, xlty and xeqy;
- enter RUN.
REQ-016 On each RUN edge, the block SHALL process the current slice:
- If xgty or xlty is high from compr_2 and no result is latched yet, latch that result.
- Then shift both registers left by 2 and decrement the counter.
REQ-017 Slice k is processed on the k-th edge after the accept edge, with k = 1 for the MSB slice.
REQ-018 done SHALL be high for exactly the one cycle spent in DONE.
REQ-019 On the edge that enters DONE, exactly one of xgty, xlty or xeqy SHALL go high; xeqy is set only when all slices were equal.
REQ-020 Results SHALL hold from DONE until the next accepted start or reset.
REQ-021 Latency without early exit: DONE is entered on edge WIDTH/2 after the accept edge, regardless of data.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 Changes on a or b after acceptance SHALL NOT affect the result.
REQ-024 A start that is high in the cycle after DONE (state IDLE) SHALL be accepted, giving a back-to-back issue interval of WIDTH/2+2 cycles.

Reset
REQ-025 rst=1 at a clock edge SHALL force the following, with priority over start:
- state IDLE;
- busy=0, done=0, xgty=0, xlty=0, xeqy=0;
- shift registers and slice counter cleared.
REQ-026 Reset during RUN SHALL abort the compare with no done pulse; the first start after rst deasserts is accepted normally.

Configuration
REQ-027 Macro CMP_SEQ_CTRL_EARLY_EXIT_EN controls early termination.
- Defined: RUN->DONE occurs on the edge that processes the first differing slice k, so DONE is entered on edge k after the accept edge (1 <= k <= WIDTH/2). Equal operands still take WIDTH/2 edges.
- Undefined: latency is fixed per REQ-021.
- Result values SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-028 a=8'hA5, b=8'hA5, start pulse -> xeqy=1, xgty=0, xlty=0; done high after edge 4 in both builds.
REQ-029 a=8'hC0, b=8'h80 -> xgty=1; done after edge 1 with CMP_SEQ_CTRL_EARLY_EXIT_EN, after edge 4 without.
REQ-030 a=8'h12, b=8'h13 -> xlty=1, with done after edge 4 in both builds; a and b changed to 8'hFF/8'h00 during RUN -> no effect on the result.
REQ-031 start re-pulsed during RUN and DONE -> ignored, single done pulse; start held high continuously -> new compare accepted every 6 cycles (no early exit).
REQ-032 a=8'h00, b=8'hFF, start, then rst on edge 2 -> no done pulse, all outputs 0, busy=0; next start with a=8'hFF, b=8'h00 -> xgty=1.

Source files
------------

// File: rtl/cmp_seq_ctrl.sv
// Sequential magnitude comparator: 2 bits per cycle, MSB slice first, via one compr_2.
// Build option CMP_SEQ_CTRL_EARLY_EXIT_EN ends the compare on the first differing slice.

module compr_2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       xgty,
  output logic       xlty,
  output logic       xeqy
);
  assign xgty = (x > y);
  assign xlty = (x < y);
  assign xeqy = (x == y);
endmodule

module cmp_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             xgty,
  output logic             xlty,
  output logic             xeqy
);
  localparam int SLICES = WIDTH / 2;
  localparam int CW     = $clog2(SLICES + 1);
`ifdef CMP_SEQ_CTRL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, w_a_next, w_b_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_lat_gt, r_lat_lt, w_lat_gt_next, w_lat_lt_next;
  logic             r_xgty, r_xlty, r_xeqy, w_xgty_next, w_xlty_next, w_xeqy_next;
  logic             w_sgt, w_slt, w_seq, w_hit;

  compr_2 u_compr_2 (
    .x    (r_a[WIDTH-1 -: 2]),
    .y    (r_b[WIDTH-1 -: 2]),
    .xgty (w_sgt),
    .xlty (w_slt),
    .xeqy (w_seq)
  );

  // First differing slice decides the result; later slices cannot override it.
  assign w_hit = !w_seq && !(r_lat_gt || r_lat_lt);

  always_comb begin
    w_state_next  = r_state;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_cnt_next    = r_cnt;
    w_lat_gt_next = r_lat_gt;
    w_lat_lt_next = r_lat_lt;
    w_xgty_next   = r_xgty;
    w_xlty_next   = r_xlty;
    w_xeqy_next   = r_xeqy;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_next      = a;
          w_b_next      = b;
          w_cnt_next    = CW'(SLICES);
          w_lat_gt_next = 1'b0;
          w_lat_lt_next = 1'b0;
          w_xgty_next   = 1'b0;
          w_xlty_next   = 1'b0;
          w_xeqy_next   = 1'b0;
          w_state_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (w_hit) begin
          w_lat_gt_next = w_sgt;
          w_lat_lt_next = w_slt;
        end
        w_a_next   = r_a << 2;
        w_b_next   = r_b << 2;
        w_cnt_next = r_cnt - CW'(1);
        if ((r_cnt == CW'(1)) || (EARLY && w_hit)) begin
          w_state_next = S_DONE;
          w_xgty_next  = w_lat_gt_next;
          w_xlty_next  = w_lat_lt_next;
          w_xeqy_next  = !(w_lat_gt_next || w_lat_lt_next);
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_lat_gt <= 1'b0;
      r_lat_lt <= 1'b0;
      r_xgty   <= 1'b0;
      r_xlty   <= 1'b0;
      r_xeqy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_cnt    <= w_cnt_next;
      r_lat_gt <= w_lat_gt_next;
      r_lat_lt <= w_lat_lt_next;
      r_xgty   <= w_xgty_next;
      r_xlty   <= w_xlty_next;
      r_xeqy   <= w_xeqy_next;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign xgty = r_xgty;
  assign xlty = r_xlty;
  assign xeqy = r_xeqy;
endmodule
